// File: rtl/pla_xgmii_frame_arb_pkg.sv
// Shared XGMII constants, arbiter state encoding and word helpers.
package pla_xgmii_pkg;

   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam int unsigned XGMII_W    = 36;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_GAP
   } state_t;

   // True when any lane carries a control-flagged terminate character.
   function automatic logic f_has_term(input logic [XGMII_W-1:0] w);
      logic t;
      t = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (w[32+k] && (w[8*k +: 8] == XGMII_TERM)) t = 1'b1;
      end
      return t;
   endfunction

endpackage

// File: rtl/pla_xgmii_frame_arb_if.sv
// FIFO-side and datapath-side signals of the frame arbiter.
interface pla_xgmii_frame_arb_if #(
   parameter int unsigned N_PORT = 2
);
   localparam int unsigned SEL_W = $clog2(N_PORT);

   logic [N_PORT-1:0] I_fifo_empty;
   logic [35:0]       I_sel_rdata;
   logic [N_PORT-1:0] O_fifo_rd;
   logic [SEL_W-1:0]  O_sel;
   logic              O_word_vld;
   logic              O_sof;
   logic              O_eof;
   logic              O_idle_ins;

   // Arbiter side.
   modport master (
      input  I_fifo_empty, I_sel_rdata,
      output O_fifo_rd, O_sel, O_word_vld, O_sof, O_eof, O_idle_ins
   );

   // FIFO / datapath side.
   modport slave (
      output I_fifo_empty, I_sel_rdata,
      input  O_fifo_rd, O_sel, O_word_vld, O_sof, O_eof, O_idle_ins
   );
endinterface

// File: rtl/pla_xgmii_frame_arb_rr_pick.sv
// Combinational round-robin picker: first requester after the last winner, wrapping.
module pla_rr_pick #(
   parameter int unsigned N     = 2,
   parameter int unsigned SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [SEL_W-1:0] i_last_ptr,
   output logic             o_gnt_vld,
   output logic [SEL_W-1:0] o_gnt_idx
);

   int w_idx;

   // Scan from farthest to nearest so the nearest requester after the pointer wins.
   always_comb begin
      o_gnt_vld = 1'b0;
      o_gnt_idx = '0;
      w_idx     = 0;
      for (int i = int'(N); i >= 1; i--) begin
         w_idx = (int'(i_last_ptr) + i) % int'(N);
         if (i_req[w_idx]) begin
            o_gnt_vld = 1'b1;
            o_gnt_idx = SEL_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/pla_xgmii_frame_arb.sv
// Frame-level round-robin arbiter sharing one XGMII lane among N_PORT FWFT FIFOs.
module pla_xgmii_frame_arb
   import pla_xgmii_pkg::*;
#(
   parameter int unsigned N_PORT  = 2,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned GAP_CYC = 2,
   parameter int unsigned TMO_W   = 12,
   parameter int unsigned MAX_CYC = 2500
) (
   input  logic               I_pla_312m5_clk,
   input  logic               I_pla_rst_n,
   input  logic               I_arb_en,
   input  logic [N_PORT-1:0]  I_frame_in,
   output logic               O_err_tmo,
   output logic [N_PORT-1:0]  O_err_ovf,
   pla_xgmii_frame_arb_if.master bus
);

   localparam int unsigned SEL_W = $clog2(N_PORT);
   localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

   state_t             r_state;
   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   r_ptr;
   logic               r_first;
   logic [TMO_W-1:0]   r_cyc;
   logic [GAP_W-1:0]   r_gap;
   logic [CNT_W-1:0]   r_fcnt [N_PORT];

   logic [N_PORT-1:0]  w_req;
   logic [N_PORT-1:0]  w_rd;
   logic [N_PORT-1:0]  w_dec;
   logic               w_gnt_vld;
   logic [SEL_W-1:0]   w_gnt_idx;
   logic               w_in_read;
   logic               w_head_vld;
   logic               w_term;
   logic               w_tmo;
   logic               w_pop;
   logic               w_eof;
   logic               w_done;

   pla_rr_pick #(.N(N_PORT), .SEL_W(SEL_W)) u_pick (
      .i_req      (w_req),
      .i_last_ptr (r_ptr),
      .o_gnt_vld  (w_gnt_vld),
      .o_gnt_idx  (w_gnt_idx)
   );

   // A terminate pop on the last allowed cycle completes normally instead of aborting.
   assign w_in_read  = (r_state == ST_READ);
   assign w_head_vld = !bus.I_fifo_empty[r_sel];
   assign w_term     = f_has_term(bus.I_sel_rdata);
   assign w_tmo      = w_in_read && (r_cyc == TMO_W'(MAX_CYC - 1)) && !(w_head_vld && w_term);
   assign w_pop      = w_in_read && w_head_vld && !w_tmo;
   assign w_eof      = w_pop && w_term;
   assign w_done     = w_eof || w_tmo;

   // Per-port request, pop strobe, frame-end decrement and overflow pulse.
   always_comb begin
      w_req     = '0;
      w_rd      = '0;
      w_dec     = '0;
      O_err_ovf = '0;
      if (w_pop)  w_rd[r_sel]  = 1'b1;
      if (w_done) w_dec[r_sel] = 1'b1;
      for (int n = 0; n < int'(N_PORT); n++) begin
         w_req[n]     = (r_fcnt[n] != '0);
         O_err_ovf[n] = I_frame_in[n] && !w_dec[n] && (r_fcnt[n] == '1);
      end
   end

   assign bus.O_fifo_rd  = w_rd;
   assign bus.O_sel      = r_sel;
   assign bus.O_word_vld = w_pop;
   assign bus.O_sof      = w_pop && r_first;
   assign bus.O_eof      = w_eof;
   assign bus.O_idle_ins = !w_pop;
   assign O_err_tmo      = w_tmo;

   // Arbitration FSM: grant in IDLE, stream the frame in READ, enforce the gap in GAP.
   always_ff @(posedge I_pla_312m5_clk or negedge I_pla_rst_n) begin
      if (!I_pla_rst_n) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
         r_ptr   <= SEL_W'(N_PORT - 1);
         r_first <= 1'b0;
         r_cyc   <= '0;
         r_gap   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (I_arb_en && w_gnt_vld) begin
                  r_sel   <= w_gnt_idx;
                  r_ptr   <= w_gnt_idx;
                  r_first <= 1'b1;
                  r_cyc   <= '0;
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               if (w_pop) r_first <= 1'b0;
               if (w_done) begin
                  r_gap   <= '0;
                  r_state <= ST_GAP;
               end else begin
                  r_cyc <= r_cyc + TMO_W'(1);
               end
            end
            ST_GAP: begin
               if (r_gap == GAP_W'(GAP_CYC - 1)) r_state <= ST_IDLE;
               else                              r_gap   <= r_gap + GAP_W'(1);
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Complete-frame counters: saturate on increment, floor at zero on decrement.
   always_ff @(posedge I_pla_312m5_clk or negedge I_pla_rst_n) begin
      if (!I_pla_rst_n) begin
         for (int n = 0; n < int'(N_PORT); n++) r_fcnt[n] <= '0;
      end else begin
         for (int n = 0; n < int'(N_PORT); n++) begin
            if (I_frame_in[n] && !w_dec[n]) begin
               if (r_fcnt[n] != '1) r_fcnt[n] <= r_fcnt[n] + CNT_W'(1);
            end else if (w_dec[n] && !I_frame_in[n]) begin
               if (r_fcnt[n] != '0) r_fcnt[n] <= r_fcnt[n] - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_pla_xgmii_frame_arb.sv
// Directed bench for the XGMII frame arbiter: per-cycle vector table plus corner sequences.
module tb_pla_xgmii_frame_arb;
   import pla_xgmii_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       arb_en = 1'b1;
   logic [1:0] frame_in = 2'b00;
   logic       err_tmo;
   logic [1:0] err_ovf;

   pla_xgmii_frame_arb_if #(.N_PORT(2)) bus ();

   pla_xgmii_frame_arb #(
      .N_PORT(2), .CNT_W(8), .GAP_CYC(2), .TMO_W(12), .MAX_CYC(16)
   ) dut (
      .I_pla_312m5_clk (clk),
      .I_pla_rst_n     (rst_n),
      .I_arb_en        (arb_en),
      .I_frame_in      (frame_in),
      .O_err_tmo       (err_tmo),
      .O_err_ovf       (err_ovf),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   logic [35:0] q0[$];
   logic [35:0] q1[$];
   logic [1:0]  stall = 2'b00;
   logic [1:0]  fi = 2'b00;

   logic [1:0]  s_rd, s_ovf;
   logic        s_vld, s_sof, s_eof, s_idle, s_sel, s_tmo;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0] fi;
      logic [1:0] rd;
      logic       sof;
      logic       eof;
      logic       idle;
      logic       sel;
   } vec_t;

   vec_t tv[17];

   function automatic vec_t mk(logic [1:0] f, logic [1:0] rd, logic sof, logic eof,
                               logic idle, logic sel);
      vec_t v;
      v.fi = f; v.rd = rd; v.sof = sof; v.eof = eof; v.idle = idle; v.sel = sel;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // FWFT FIFO model: head word of the currently selected queue.
   task automatic drive_fifo();
      bus.I_fifo_empty[0] = (q0.size() == 0) || stall[0];
      bus.I_fifo_empty[1] = (q1.size() == 0) || stall[1];
      if (bus.O_sel == 1'b1) bus.I_sel_rdata = (q1.size() != 0) ? q1[0] : 36'h0;
      else                   bus.I_sel_rdata = (q0.size() != 0) ? q0[0] : 36'h0;
   endtask

   task automatic sample();
      s_rd = bus.O_fifo_rd; s_vld = bus.O_word_vld; s_sof = bus.O_sof;
      s_eof = bus.O_eof; s_idle = bus.O_idle_ins; s_sel = bus.O_sel;
      s_tmo = err_tmo; s_ovf = err_ovf;
   endtask

   // One clock: drive on negedge, sample 1ns later, pop the model after posedge.
   task automatic cycle();
      @(negedge clk);
      frame_in = fi;
      drive_fifo();
      #1 sample();
      @(posedge clk);
      if (s_rd[0] && q0.size() != 0) q0.delete(0);
      if (s_rd[1] && q1.size() != 0) q1.delete(0);
      fi = 2'b00;
   endtask

   task automatic push_frame(input int port, input int nw, input bit term);
      logic [35:0] w;
      for (int i = 0; i < nw; i++) begin
         if (term && i == nw - 1) w = {4'hF, XGMII_IDLE, XGMII_IDLE, XGMII_IDLE, XGMII_TERM};
         else if (i == 0)         w = {4'h1, 8'hD5, 8'h55, 8'h55, XGMII_START};
         else                     w = {4'h0, 32'h1000_0000 + 32'(i)};
         if (port == 0) q0.push_back(w); else q1.push_back(w);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      q0.delete(); q1.delete();
      stall = 2'b00; fi = 2'b00; frame_in = 2'b00; arb_en = 1'b1;
      drive_fifo();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   int pops, pops0, pops1, scnt, neof, ntmo, ngr, words, idle_since, novf;
   int t_sof0, t_tmo, t_sof1;
   bit done, seen_eof;
   logic [1:0] got[6];

   initial begin
      drive_fifo();
      #1 sample();
      check("reset_outputs", 32'({s_rd, s_vld, s_sof, s_eof, s_idle, s_sel, s_tmo, s_ovf}),
            32'({2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00}));

      // Test 1: 5-word frame on port 0, then a 2-word frame on port 1.
      do_reset();
      push_frame(0, 5, 1);
      tv[0]  = mk(2'b01, 2'b00, 0, 0, 1, 0);
      tv[1]  = mk(2'b00, 2'b00, 0, 0, 1, 0);
      tv[2]  = mk(2'b00, 2'b01, 1, 0, 0, 0);
      tv[3]  = mk(2'b00, 2'b01, 0, 0, 0, 0);
      tv[4]  = mk(2'b00, 2'b01, 0, 0, 0, 0);
      tv[5]  = mk(2'b00, 2'b01, 0, 0, 0, 0);
      tv[6]  = mk(2'b00, 2'b01, 0, 1, 0, 0);
      tv[7]  = mk(2'b00, 2'b00, 0, 0, 1, 0);
      tv[8]  = mk(2'b00, 2'b00, 0, 0, 1, 0);
      tv[9]  = mk(2'b00, 2'b00, 0, 0, 1, 0);
      tv[10] = mk(2'b10, 2'b00, 0, 0, 1, 0);
      tv[11] = mk(2'b00, 2'b00, 0, 0, 1, 0);
      tv[12] = mk(2'b00, 2'b10, 1, 0, 0, 1);
      tv[13] = mk(2'b00, 2'b10, 0, 1, 0, 1);
      tv[14] = mk(2'b00, 2'b00, 0, 0, 1, 1);
      tv[15] = mk(2'b00, 2'b00, 0, 0, 1, 1);
      tv[16] = mk(2'b00, 2'b00, 0, 0, 1, 1);
      for (int i = 0; i < 17; i++) begin
         if (i == 10) push_frame(1, 2, 1);
         fi = tv[i].fi;
         cycle();
         check($sformatf("t1_vec%0d", i),
               32'({s_rd, s_vld, s_sof, s_eof, s_idle, s_sel}),
               32'({tv[i].rd, (tv[i].rd != 2'b00), tv[i].sof, tv[i].eof, tv[i].idle, tv[i].sel}));
      end
      check("t1_fifos_drained", 32'(q0.size() + q1.size()), 32'(0));

      // Test 2: three 3-word frames pending on each port alternate 0,1,0,1,0,1.
      do_reset();
      for (int f = 0; f < 3; f++) begin push_frame(0, 3, 1); push_frame(1, 3, 1); end
      neof = 0; ngr = 0; words = 0; idle_since = 0; seen_eof = 0;
      for (int c = 0; c < 200 && neof < 6; c++) begin
         if (c < 3) fi = 2'b11;
         cycle();
         if (s_sof) begin
            if (ngr < 6) got[ngr] = {1'b0, s_sel};
            ngr++;
            words = 0;
            if (seen_eof) check("t2_gap", 32'(idle_since), 32'(3));
         end
         if (s_vld) words++;
         if (s_eof) begin
            check("t2_words", 32'(words), 32'(3));
            neof++; seen_eof = 1; idle_since = 0;
         end else if (!s_vld) idle_since++;
      end
      check("t2_eof_count", 32'(neof), 32'(6));
      for (int i = 0; i < 6; i++) check($sformatf("t2_grant%0d", i), 32'(got[i]), 32'(i % 2));

      // Test 3: FIFO empty for 4 cycles after the second pop of a 6-word frame.
      do_reset();
      push_frame(0, 6, 1);
      fi = 2'b01;
      cycle();
      pops = 0; scnt = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         stall[0] = (pops == 2) && (scnt < 4);
         cycle();
         if (stall[0]) begin
            check("t3_stall_nopop", 32'({s_rd, s_idle}), 32'({2'b00, 1'b1}));
            scnt++;
         end
         if (s_vld) pops++;
         if (s_eof) done = 1;
      end
      stall = 2'b00;
      check("t3_stall_cycles", 32'(scnt), 32'(4));
      check("t3_word_count", 32'(pops), 32'(6));
      check("t3_eof_seen", 32'(done), 32'(1));

      // Test 4: port 0 frame with no terminate times out; port 1 follows after the gap.
      do_reset();
      push_frame(0, 40, 0);
      push_frame(1, 3, 1);
      fi = 2'b11;
      cycle();
      pops0 = 0; pops1 = 0; ntmo = 0; t_sof0 = -1; t_tmo = -1; t_sof1 = -1;
      for (int c = 0; c < 80; c++) begin
         cycle();
         if (s_sof && s_sel == 1'b0) t_sof0 = c;
         if (s_sof && s_sel == 1'b1) t_sof1 = c;
         if (s_vld && s_sel == 1'b0) pops0++;
         if (s_vld && s_sel == 1'b1) pops1++;
         if (s_tmo) begin
            ntmo++; t_tmo = c;
            check("t4_tmo_nopop", 32'(s_rd), 32'(0));
         end
      end
      check("t4_tmo_count", 32'(ntmo), 32'(1));
      check("t4_tmo_cycle", 32'(t_tmo - t_sof0), 32'(15));
      check("t4_port0_pops", 32'(pops0), 32'(15));
      check("t4_next_grant", 32'(t_sof1 - t_tmo), 32'(4));
      check("t4_port1_pops", 32'(pops1), 32'(3));
      check("t4_residual", 32'(q0.size()), 32'(25));

      // Test 5a: frame_in and eof on port 1 in the same cycle leave the count unchanged.
      do_reset();
      push_frame(1, 2, 1); push_frame(1, 2, 1);
      fi = 2'b10; cycle();
      fi = 2'b10; cycle();
      cycle();
      push_frame(1, 2, 1);
      fi = 2'b10; cycle();
      check("t5_eof_coincident", 32'({s_eof, s_sel}), 32'({1'b1, 1'b1}));
      neof = 1; ntmo = 0;
      for (int c = 0; c < 80; c++) begin
         cycle();
         if (s_eof) neof++;
         if (s_tmo) ntmo++;
      end
      check("t5_total_frames", 32'(neof), 32'(3));
      check("t5_no_tmo", 32'(ntmo), 32'(0));

      // Test 5b: counter saturation at 255 with grants disabled.
      do_reset();
      arb_en = 1'b0;
      novf = 0; pops = 0;
      for (int i = 0; i < 255; i++) begin
         fi = 2'b10; cycle();
         if (s_ovf != 2'b00) novf++;
         if (s_vld) pops++;
      end
      check("t5_no_early_ovf", 32'(novf), 32'(0));
      fi = 2'b10; cycle();
      check("t5_ovf_first", 32'(s_ovf), 32'(2'b10));
      fi = 2'b10; cycle();
      check("t5_ovf_held", 32'(s_ovf), 32'(2'b10));
      check("t5_no_grant_disabled", 32'(pops), 32'(0));
      arb_en = 1'b1;

      // Test 6: asynchronous reset in the middle of a port 1 frame.
      do_reset();
      push_frame(1, 8, 1);
      fi = 2'b10; cycle();
      pops = 0;
      for (int c = 0; c < 10 && pops < 2; c++) begin
         cycle();
         if (s_vld) pops++;
      end
      check("t6_mid_frame", 32'(pops), 32'(2));
      @(negedge clk);
      drive_fifo();
      #2 rst_n = 1'b0;
      #1 sample();
      check("t6_async_reset", 32'({s_rd, s_vld, s_sof, s_eof, s_idle, s_sel, s_tmo, s_ovf}),
            32'({2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00}));
      q0.delete(); q1.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_frame(0, 3, 1);
      fi = 2'b01; cycle();
      check("t6_lat_c0", 32'(s_rd), 32'(2'b00));
      cycle();
      check("t6_lat_c1", 32'(s_rd), 32'(2'b00));
      cycle();
      check("t6_lat_c2", 32'({s_rd, s_sof}), 32'({2'b01, 1'b1}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
